// File: rtl/xgriscv_mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single shared memory port.
// Round-robin between ports on contention, with a per-access wait timeout.
module xgriscv_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch port
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ivalid,
  output logic [XLEN-1:0]   irdata,
  // data port
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [XLEN-1:0]   dwdata,
  input  logic [3:0]        damp,
  output logic              dvalid,
  output logic [XLEN-1:0]   drdata,
  output logic              err,
  // shared memory port
  output logic              mreq,
  output logic              mwe,
  output logic [ADDR_W-1:0] maddr,
  output logic [XLEN-1:0]   mwdata,
  output logic [3:0]        mamp,
  input  logic              mready,
  input  logic [XLEN-1:0]   mrdata
);

  localparam int unsigned     CNT_W    = 8;
  // Abort is decided in the TIMEOUT-th waiting cycle, so mreq stays up TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             last;      // 1 = data port was served most recently
  logic [CNT_W-1:0] wait_cnt;
  logic             ireq_act;
  logic             dreq_act;
  logic             grant_i;
  logic             grant_d;
  logic             done;
  logic             abort;

  // A port whose completion is being reported this cycle does not compete.
  assign ireq_act = ireq & ~ivalid;
  assign dreq_act = dreq & ~dvalid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Arbitration and access-termination decode.
  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (ireq_act && (!dreq_act || last)) begin
          grant_i = 1'b1;
          state_n = BUSY_I;
        end else if (dreq_act) begin
          grant_d = 1'b1;
          state_n = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mready) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latching, memory port drive, wait counter and completion reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      mreq     <= 1'b0;
      mwe      <= 1'b0;
      maddr    <= '0;
      mwdata   <= '0;
      mamp     <= 4'b0000;
      ivalid   <= 1'b0;
      dvalid   <= 1'b0;
      err      <= 1'b0;
      irdata   <= '0;
      drdata   <= '0;
      wait_cnt <= '0;
      last     <= 1'b1;
    end else begin
      ivalid <= 1'b0;
      dvalid <= 1'b0;
      err    <= 1'b0;
      if (grant_i) begin
        mreq     <= 1'b1;
        mwe      <= 1'b0;
        maddr    <= iaddr;
        mwdata   <= '0;
        mamp     <= 4'b1111;
        wait_cnt <= '0;
      end else if (grant_d) begin
        mreq     <= 1'b1;
        mwe      <= dwe;
        maddr    <= daddr;
        mwdata   <= dwdata;
        mamp     <= damp;
        wait_cnt <= '0;
      end else if (done) begin
        mreq <= 1'b0;
        last <= (state == BUSY_D);
        if (state == BUSY_D) begin
          dvalid <= 1'b1;
          if (!mwe) drdata <= mrdata;
        end else begin
          ivalid <= 1'b1;
          irdata <= mrdata;
        end
      end else if (abort) begin
        mreq <= 1'b0;
        err  <= 1'b1;
        last <= (state == BUSY_D);
        if (state == BUSY_D) dvalid <= 1'b1;
        else                 ivalid <= 1'b1;
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
// Directed bench for xgriscv_mem_arbiter: a default-timeout instance with a
// latency-programmable memory responder, and a TIMEOUT=4 instance whose memory never answers.
module tb_xgriscv_mem_arbiter;

  typedef struct {
    logic        port;   // 0 = fetch, 1 = data
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic        ireq = 0, dreq = 0, dwe = 0, mready = 0;
  logic [31:0] iaddr = 0, daddr = 0, dwdata = 0, mrdata = 0;
  logic [3:0]  damp = 0;
  logic        ivalid, dvalid, err, mreq, mwe;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic [3:0]  mamp;

  // timeout instance
  logic        t_dreq = 0;
  logic [31:0] t_daddr = 0;
  logic        t_mready = 0;
  logic [31:0] t_mrdata = 32'h5555_AAAA;
  logic        t_ivalid, t_dvalid, t_err, t_mreq, t_mwe;
  logic [31:0] t_irdata, t_drdata, t_maddr, t_mwdata;
  logic [3:0]  t_mamp;

  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 0;
  int   wcnt = 0;
  exp_t sb[$];

  xgriscv_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .ivalid(ivalid), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .damp(damp),
    .dvalid(dvalid), .drdata(drdata), .err(err),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata), .mamp(mamp),
    .mready(mready), .mrdata(mrdata)
  );

  xgriscv_mem_arbiter #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset),
    .ireq(1'b0), .iaddr(32'h0), .ivalid(t_ivalid), .irdata(t_irdata),
    .dreq(t_dreq), .dwe(1'b0), .daddr(t_daddr), .dwdata(32'h0), .damp(4'hF),
    .dvalid(t_dvalid), .drdata(t_drdata), .err(t_err),
    .mreq(t_mreq), .mwe(t_mwe), .maddr(t_maddr), .mwdata(t_mwdata), .mamp(t_mamp),
    .mready(t_mready), .mrdata(t_mrdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : ((a ^ 32'hC0DE_0000) + 32'h11);
  endfunction

  // Memory responder: answers mem_lat cycles after mreq rises.
  always @(negedge clk) begin
    if (mreq) begin
      if (wcnt == mem_lat) begin
        mready = 1'b1;
        mrdata = mem_word(maddr);
        wcnt   = 0;
      end else begin
        mready = 1'b0;
        wcnt   = wcnt + 1;
      end
    end else begin
      mready = 1'b0;
      wcnt   = 0;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare the completion being reported now against the scoreboard head.
  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_port"}, {31'd0, dvalid}, {31'd0, e.port});
      chk({tag, "_data"}, dvalid ? drdata : irdata, e.data);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  initial begin
    int busy, bad, dv, errs, got;
    logic [31:0] drd;

    // ---- reset, with both ports already requesting (contention) ----
    ireq = 1; iaddr = 32'h40;
    dreq = 1; dwe = 1; daddr = 32'h2000; dwdata = 32'hDEAD_BEEF; damp = 4'h3;
    mem_lat = 0;
    step(); step();
    chk("rst_mreq", {31'd0, mreq}, 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_mwdata", mwdata, 32'd0);
    chk("rst_mamp_mwe", {27'd0, mamp, mwe}, 32'd0);
    chk("rst_valid_err", {29'd0, ivalid, dvalid, err}, 32'd0);
    chk("rst_irdata", irdata, 32'd0);
    chk("rst_drdata", drdata, 32'd0);
    reset = 0;
    sb.push_back('{1'b0, mem_word(32'h40), 1'b0});
    sb.push_back('{1'b1, 32'h0, 1'b0});          // store leaves drdata at reset value
    step();
    chk("cont_i_mreq", {31'd0, mreq}, 32'd1);
    chk("cont_i_maddr", maddr, 32'h40);
    chk("cont_i_mwe_mamp", {27'd0, mamp, mwe}, {27'd0, 4'hF, 1'b0});
    step();
    chk("cont_ivalid", {31'd0, ivalid}, 32'd1);
    sb_check("cont_i");
    ireq = 0;
    step();
    chk("cont_d_mreq", {31'd0, mreq}, 32'd1);
    chk("cont_d_maddr", maddr, 32'h2000);
    chk("cont_d_mwe_mamp", {27'd0, mamp, mwe}, {27'd0, 4'h3, 1'b1});
    chk("cont_d_mwdata", mwdata, 32'hDEAD_BEEF);
    step();
    chk("cont_dvalid", {30'd0, ivalid, dvalid}, 32'd1);
    sb_check("cont_d");
    dreq = 0; dwe = 0;
    step();

    // ---- single fetch, minimum latency ----
    ireq = 1; iaddr = 32'h100;
    sb.push_back('{1'b0, 32'h0050_0093, 1'b0});
    step();
    chk("fetch_mreq", {31'd0, mreq}, 32'd1);
    chk("fetch_maddr", maddr, 32'h100);
    chk("fetch_mwe_mamp", {27'd0, mamp, mwe}, {27'd0, 4'hF, 1'b0});
    chk("fetch_no_early_valid", {31'd0, ivalid}, 32'd0);
    step();
    chk("fetch_ivalid", {31'd0, ivalid}, 32'd1);
    sb_check("fetch");
    ireq = 0;
    step();
    chk("fetch_ivalid_pulse", {30'd0, ivalid, mreq}, 32'd0);

    // ---- data load with 5 wait states ----
    mem_lat = 5;
    dreq = 1; dwe = 0; daddr = 32'h3000; damp = 4'hF;
    sb.push_back('{1'b1, mem_word(32'h3000), 1'b0});
    busy = 0; bad = 0; dv = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (mreq) begin
        busy++;
        if (maddr !== 32'h3000) bad++;
      end
      if (dvalid) begin
        dv++;
        sb_check("wait");
        dreq = 0;
      end
    end
    chk("wait_busy_cycles", busy, 6);
    chk("wait_maddr_stable", bad, 0);
    chk("wait_dvalid_count", dv, 1);

    // ---- round robin, both ports continuously requesting ----
    mem_lat = 1;
    ireq = 1; iaddr = 32'h500;
    dreq = 1; dwe = 0; daddr = 32'h600;
    for (int k = 0; k < 6; k++)
      sb.push_back('{k[0], (k[0] ? mem_word(32'h600) : mem_word(32'h500)), 1'b0});
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      step();
      if (ivalid && dvalid) chk("rr_both_valid", 32'd1, 32'd0);
      else if (ivalid || dvalid) begin
        got++;
        sb_check("rr");
        if (got == 6) begin ireq = 0; dreq = 0; end
      end
    end
    chk("rr_count", got, 6);
    step(); step();
    chk("rr_quiet", {31'd0, mreq}, 32'd0);

    // ---- reset in the second BUSY_I cycle ----
    mem_lat = 10;
    ireq = 1; iaddr = 32'h700;
    step();                       // first BUSY_I cycle
    step();                       // second BUSY_I cycle
    chk("rmid_busy", {31'd0, mreq}, 32'd1);
    reset = 1;
    step();
    chk("rmid_mreq", {31'd0, mreq}, 32'd0);
    chk("rmid_maddr", maddr, 32'd0);
    chk("rmid_valid", {29'd0, ivalid, dvalid, err}, 32'd0);
    chk("rmid_irdata", irdata, 32'd0);
    chk("rmid_drdata", drdata, 32'd0);
    ireq = 0; reset = 0;
    dv = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ivalid || mreq) dv++;
    end
    chk("rmid_abandoned", dv, 0);

    // ---- timeout on the TIMEOUT=4 instance ----
    t_dreq = 1; t_daddr = 32'h800;
    busy = 0; dv = 0; errs = 0; bad = 0; drd = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      step();
      if (t_mreq) busy++;
      if (t_err && !t_dvalid) bad++;
      if (t_dvalid) begin
        dv++;
        if (t_err) errs++;
        drd = t_drdata;
        t_dreq = 0;
      end
    end
    chk("to_mreq_cycles", busy, 4);
    chk("to_dvalid_count", dv, 1);
    chk("to_err_with_dvalid", errs, 1);
    chk("to_err_alone", bad, 0);
    chk("to_drdata_kept", drd, 32'd0);

    if (sb.size() != 0) chk("sb_leftover", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xgriscv_mem_arbiter.md
XGRISCV_MEM_ARBITER -- requirements
Module: xgriscv_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32: width of all address ports.
REQ-002 Parameter XLEN, 32: width of all data ports.
REQ-003 Parameter TIMEOUT, 255: maximum cycles a memory access may wait for mready before abort; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ireq  input  1  instruction-fetch request; held high until ivalid.
REQ-007 iaddr  input  ADDR_W  fetch address; stable while ireq is high.
REQ-008 ivalid  output  1  one-cycle pulse: fetch complete.
REQ-009 irdata  output  XLEN  fetched word; valid when ivalid is high.
REQ-010 dreq  input  1  data request; held high until dvalid.
REQ-011 dwe  input  1  data write enable (1=store, 0=load).
REQ-012 daddr  input  ADDR_W  data address.
REQ-013 dwdata  input  XLEN  store data.
REQ-014 damp  input  4  byte-enable mask for the data access.
REQ-015 dvalid  output  1  one-cycle pulse: data access complete.
REQ-016 drdata  output  XLEN  load data; valid when dvalid is high.
REQ-017 err  output  1  high together with ivalid/dvalid when the access timed out.
REQ-018 mreq, mwe, maddr, mwdata, mamp  output  1/1/ADDR_W/XLEN/4  request to the shared memory.
REQ-019 mready  input  1  memory completion; mrdata is valid in the same cycle.
REQ-020 mrdata  input  XLEN  memory read data.

Function
REQ-021 FSM states: IDLE, BUSY_I, BUSY_D.
REQ-022 IDLE: only ireq -> BUSY_I; only dreq -> BUSY_D; both -> grant the port not granted last (round-robin pointer `last`); neither -> stay.
REQ-023 On a grant, the block latches address, dwe, dwdata and damp into internal registers; memory outputs drive only from these registers.
REQ-024 In BUSY_*: mreq=1; maddr/mwe/mwdata/mamp held stable until mready is sampled high.
REQ-025 Fetch grants drive mwe=0 and mamp=4'b1111.
REQ-026 When mready=1 in BUSY_*: mrdata registered into irdata (BUSY_I) or drdata (BUSY_D); the matching valid pulses in the next cycle with err=0; state -> IDLE; `last` updated to the served port.
REQ-027 Minimum latency: req seen in IDLE at cycle N; mreq high at N+1; if mready=1 at N+1, valid pulses at N+2.
REQ-028 In the cycle a port's valid is high, that port's req is ignored for arbitration; the other port may be granted in that cycle.
REQ-029 irdata/drdata hold their last value until the next completion on that port; on a store, drdata is not written.
REQ-030 8-bit wait counter clears on entry to BUSY_*, increments each cycle with mready=0.
REQ-031 When the counter reaches TIMEOUT with mready=0: mreq drops, the matching valid and err pulse in the next cycle, the rdata register is not updated, state -> IDLE, and `last` is updated.
REQ-032 mready while in IDLE is ignored.
REQ-033 ivalid and dvalid are never high in the same cycle; at most one access is outstanding.

Reset
REQ-034 Synchronous reset, taking priority over all other behaviour: state=IDLE; mreq=0, mwe=0, maddr=0, mwdata=0, mamp=0; ivalid=0, dvalid=0, err=0; irdata=0, drdata=0; counter=0; last=D, so that fetch wins the first contention.
REQ-035 Reset asserted mid-access abandons the access without a valid pulse; mreq is 0 in the cycle after reset is sampled.

Verification
REQ-036 Single fetch: ireq=1, iaddr=0x100, mready=1 one cycle after mreq, mrdata=0x00500093 -> maddr=0x100, mwe=0, mamp=0xF; ivalid at N+2; irdata=0x00500093.
REQ-037 Contention: ireq and dreq both high from reset release (daddr=0x2000, dwe=1, dwdata=0xDEADBEEF, damp=0x3) -> fetch served first; data granted in the ivalid cycle; then mwe=1, mamp=0x3, mwdata=0xDEADBEEF; dvalid follows.
REQ-038 Round-robin: both requesters continuously re-request for 6 accesses -> grants alternate I,D,I,D,I,D.
REQ-039 Wait states: dreq load with mready delayed 5 cycles -> maddr stable for all 6 BUSY cycles; dvalid exactly once; err=0.
REQ-040 Timeout: TIMEOUT=4, mready tied 0, dreq load -> mreq high 4 cycles; dvalid=1 and err=1 next cycle; drdata unchanged.
REQ-041 Reset mid-access: reset asserted in the 2nd BUSY_I cycle -> no ivalid; mreq=0 the next cycle; all outputs at reset values.
